complex_issue_sched: RTL and testbench



---
 rtl/complex_issue_sched_pkg.sv | 12 +
 rtl/complex_issue_sched_age_arb2.sv | 55 +++++
 rtl/complex_issue_sched.sv | 120 ++++++++++++
 tb/tb_complex_issue_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_issue_sched_pkg.sv
// Shared definitions for the issue schedulers: FSM state encoding and default widths.
package complex_issue_sched_pkg;

  localparam int ROB_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/complex_issue_sched_age_arb2.sv
// Two-entry age arbiter: tracks which RS entry is newer and grants the older
// candidate when both compete.
module age_arb2
  import complex_issue_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cand0_i,
  input  logic cand1_i,
  input  logic issue_en_i,
  input  logic alloc0_i,
  input  logic alloc1_i,
  output logic grant0_o,
  output logic grant1_o,
  output logic selector_o
);

  logic selector_q;
  logic selector_d;

  // A simultaneous alloc of both entries treats entry 0 as older.
  always_comb begin
    selector_d = selector_q;
    if (alloc1_i) begin
      selector_d = 1'b1;
    end else if (alloc0_i) begin
      selector_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selector_q <= 1'b0;
    end else begin
      selector_q <= selector_d;
    end
  end

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (issue_en_i) begin
      if (cand0_i && cand1_i) begin
        grant0_o = selector_q;
        grant1_o = ~selector_q;
      end else begin
        grant0_o = cand0_i;
        grant1_o = cand1_i;
      end
    end
  end

  assign selector_o = selector_q;

endmodule

// File: rtl/complex_issue_sched.sv
// Complex-unit issue scheduler: age-ordered grant, in-flight tracking for
// single/multi-cycle ops, and a registered writeback handshake to the ROB.
module complex_issue_sched
  import complex_issue_sched_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int ROB_W  = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rs0_valid,
  input  logic             rs1_valid,
  input  logic             rs0_ready,
  input  logic             rs1_ready,
  input  logic             rs0_mc,
  input  logic             rs1_mc,
  input  logic [ROB_W-1:0] rs0_rob,
  input  logic [ROB_W-1:0] rs1_rob,
  input  logic             alloc0,
  input  logic             alloc1,
  input  logic             wb_ready,
  output logic             issue0,
  output logic             issue1,
  output logic             ex_sel,
  output logic             selector,
  output logic             busy,
  output logic             wb_valid,
  output logic [ROB_W-1:0] wb_rob
);

  localparam int CNT_W = $clog2(MC_LAT);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROB_W-1:0] wb_rob_q, wb_rob_d;
  logic             ex_sel_q;
  logic             issue_en;
  logic             grant;
  logic             grant_mc;
  logic [ROB_W-1:0] grant_rob;

  // Gating with rst_n keeps grants quiet while reset is held.
  assign issue_en = rst_n & ~flush &
                    ((state_q == ST_IDLE) | ((state_q == ST_WB) & wb_ready));

  age_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .cand0_i    (rs0_valid & rs0_ready),
    .cand1_i    (rs1_valid & rs1_ready),
    .issue_en_i (issue_en),
    .alloc0_i   (alloc0),
    .alloc1_i   (alloc1),
    .grant0_o   (issue0),
    .grant1_o   (issue1),
    .selector_o (selector)
  );

  assign grant     = issue0 | issue1;
  assign grant_mc  = issue1 ? rs1_mc : rs0_mc;
  assign grant_rob = issue1 ? rs1_rob : rs0_rob;
  assign ex_sel    = issue1 ? 1'b1 : (issue0 ? 1'b0 : ex_sel_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_rob_d = wb_rob_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_EXEC: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_WB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
      // A grant only happens from IDLE or an accepted WB, so it overrides both.
      if (grant) begin
        wb_rob_d = grant_rob;
        if (grant_mc) begin
          state_d = ST_EXEC;
          cnt_d   = CNT_W'(MC_LAT - 1);
        end else begin
          state_d = ST_WB;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wb_rob_q <= '0;
      ex_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_rob_q <= wb_rob_d;
      ex_sel_q <= ex_sel;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign wb_valid = (state_q == ST_WB);
  assign wb_rob   = wb_rob_q;

endmodule

// File: tb/tb_complex_issue_sched.sv
// Directed bench for complex_issue_sched: grant checks inline, writebacks
// checked in order against a scoreboard queue by an independent monitor.
module tb_complex_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       rs0_valid = 1'b0, rs1_valid = 1'b0;
  logic       rs0_ready = 1'b0, rs1_ready = 1'b0;
  logic       rs0_mc = 1'b0, rs1_mc = 1'b0;
  logic [3:0] rs0_rob = '0, rs1_rob = '0;
  logic       alloc0 = 1'b0, alloc1 = 1'b0;
  logic       wb_ready = 1'b1;
  logic       issue0, issue1, ex_sel, selector, busy, wb_valid;
  logic [3:0] wb_rob;

  int n_cmp = 0;
  int n_bad = 0;
  int wb_cnt = 0;
  int grant_cnt = 0;
  logic [3:0] exp_q[$];

  complex_issue_sched #(.MC_LAT(4), .ROB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rs0_valid(rs0_valid), .rs1_valid(rs1_valid),
    .rs0_ready(rs0_ready), .rs1_ready(rs1_ready),
    .rs0_mc(rs0_mc), .rs1_mc(rs1_mc),
    .rs0_rob(rs0_rob), .rs1_rob(rs1_rob),
    .alloc0(alloc0), .alloc1(alloc1), .wb_ready(wb_ready),
    .issue0(issue0), .issue1(issue1), .ex_sel(ex_sel), .selector(selector),
    .busy(busy), .wb_valid(wb_valid), .wb_rob(wb_rob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_rs();
    rs0_valid = 1'b0; rs0_ready = 1'b0; rs0_mc = 1'b0;
    rs1_valid = 1'b0; rs1_ready = 1'b0; rs1_mc = 1'b0;
  endtask

  // Writeback monitor: each accepted result must match the oldest expected ROB index.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      wb_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got rob %0d expected none at %0t", wb_rob, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("wb_rob", int'(wb_rob), int'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a ready candidate
    rs0_valid = 1'b1; rs0_ready = 1'b1; rs0_rob = 4'd5;
    smp();
    check("rst_issue0", int'(issue0), 0);
    check("rst_wb_valid", int'(wb_valid), 0);
    check("rst_selector", int'(selector), 0);
    check("rst_busy", int'(busy), 0);
    nxt();
    rst_n = 1'b1;
    smp();
    check("rel_issue0", int'(issue0), 1);
    check("rel_ex_sel", int'(ex_sel), 0);
    exp_q.push_back(4'd5);
    nxt(); clear_rs();
    smp();
    check("rel_busy", int'(busy), 1);
    check("rel_wb_valid", int'(wb_valid), 1);
    nxt();
    smp();
    check("rel_idle", int'(busy), 0);

    // Age select: entry 1 allocated first, then entry 0
    nxt();
    alloc1 = 1'b1; rs1_valid = 1'b1; rs1_rob = 4'd9;
    smp();
    nxt();
    alloc1 = 1'b0; alloc0 = 1'b1; rs0_valid = 1'b1; rs0_rob = 4'd3;
    smp();
    check("age_sel_after_alloc1", int'(selector), 1);
    nxt();
    alloc0 = 1'b0; rs0_ready = 1'b1; rs1_ready = 1'b1;
    smp();
    check("age_selector", int'(selector), 0);
    check("age_issue1", int'(issue1), 1);
    check("age_issue0", int'(issue0), 0);
    check("age_ex_sel", int'(ex_sel), 1);
    exp_q.push_back(4'd9);
    nxt();
    rs1_valid = 1'b0; rs1_ready = 1'b0;
    smp();
    check("age_second_issue0", int'(issue0), 1);
    check("age_second_ex_sel", int'(ex_sel), 0);
    exp_q.push_back(4'd3);
    nxt(); clear_rs();
    smp();
    nxt();

    // Both allocated together: entry 0 is older
    alloc0 = 1'b1; alloc1 = 1'b1; rs0_valid = 1'b1; rs1_valid = 1'b1;
    rs0_rob = 4'd1; rs1_rob = 4'd2;
    smp();
    nxt();
    alloc0 = 1'b0; alloc1 = 1'b0; rs0_ready = 1'b1; rs1_ready = 1'b1;
    smp();
    check("both_alloc_selector", int'(selector), 1);
    check("both_alloc_issue0", int'(issue0), 1);
    exp_q.push_back(4'd1);
    nxt();
    rs0_valid = 1'b0; rs0_ready = 1'b0;
    smp();
    check("both_alloc_issue1", int'(issue1), 1);
    exp_q.push_back(4'd2);
    nxt(); clear_rs();
    smp();
    nxt();

    // Multi-cycle op, MC_LAT=4
    rs0_valid = 1'b1; rs0_ready = 1'b1; rs0_mc = 1'b1; rs0_rob = 4'd7;
    smp();
    check("mc_issue0", int'(issue0), 1);
    exp_q.push_back(4'd7);
    nxt(); clear_rs();
    rs1_valid = 1'b1; rs1_ready = 1'b1; rs1_rob = 4'd2;
    for (int i = 1; i <= 3; i++) begin
      smp();
      check($sformatf("mc_no_grant_c%0d", i), int'(issue1), 0);
      check($sformatf("mc_busy_c%0d", i), int'(busy), 1);
      check($sformatf("mc_no_wb_c%0d", i), int'(wb_valid), 0);
      nxt();
    end
    smp();
    check("mc_wb_valid", int'(wb_valid), 1);
    check("mc_next_issue1", int'(issue1), 1);
    exp_q.push_back(4'd2);
    nxt(); clear_rs();
    smp();
    nxt();

    // Backpressure
    rs0_valid = 1'b1; rs0_ready = 1'b1; rs0_rob = 4'd4;
    smp();
    check("bp_issue0", int'(issue0), 1);
    exp_q.push_back(4'd4);
    nxt(); clear_rs();
    rs1_valid = 1'b1; rs1_ready = 1'b1; rs1_rob = 4'd6; wb_ready = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      smp();
      check($sformatf("bp_wb_valid_c%0d", i), int'(wb_valid), 1);
      check($sformatf("bp_wb_rob_c%0d", i), int'(wb_rob), 4);
      check($sformatf("bp_no_grant_c%0d", i), int'(issue1), 0);
      nxt();
    end
    wb_ready = 1'b1;
    smp();
    check("bp_accept_wb_rob", int'(wb_rob), 4);
    check("bp_accept_issue1", int'(issue1), 1);
    exp_q.push_back(4'd6);
    nxt(); clear_rs();
    smp();
    nxt();

    // Flush during EXEC
    rs0_valid = 1'b1; rs0_ready = 1'b1; rs0_mc = 1'b1; rs0_rob = 4'd11;
    smp();
    check("fl_issue0", int'(issue0), 1);
    nxt(); clear_rs();
    smp();
    check("fl_exec_busy", int'(busy), 1);
    nxt();
    flush = 1'b1; rs1_valid = 1'b1; rs1_ready = 1'b1; rs1_rob = 4'd13;
    smp();
    check("fl_no_grant", int'(issue1), 0);
    nxt();
    flush = 1'b0;
    smp();
    check("fl_idle", int'(busy), 0);
    check("fl_no_wb", int'(wb_valid), 0);
    check("fl_regrant", int'(issue1), 1);
    exp_q.push_back(4'd13);
    nxt(); clear_rs();
    smp();
    nxt();

    // Throughput: six single-cycle ops alternating entries
    for (int k = 0; k < 6; k++) begin
      clear_rs();
      if (k % 2 == 0) begin
        rs0_valid = 1'b1; rs0_ready = 1'b1; rs0_rob = 4'(k);
      end else begin
        rs1_valid = 1'b1; rs1_ready = 1'b1; rs1_rob = 4'(8 + k);
      end
      smp();
      if (issue0 || issue1) grant_cnt++;
      check($sformatf("tp_ex_sel_%0d", k), int'(ex_sel), k % 2);
      exp_q.push_back((k % 2 == 0) ? 4'(k) : 4'(8 + k));
      nxt();
    end
    clear_rs();
    smp();
    check("tp_grant_count", grant_cnt, 6);
    nxt();
    smp();
    check("sb_drained", exp_q.size(), 0);
    check("wb_total", wb_cnt, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
